mac_array_dotprod_engine: RTL and testbench
===========================================

Name: mac_array_dotprod_engine

Overview:
- Parametrised successor to the fixed-size multi-precision MAC array.
- NUM_LANES signed INT8 or packed dual-INT4 lanes accumulate over a programmable vector length (cfg_len beats).
- Lane accumulators are reduced through a pipelined, registered adder tree; the scalar result is presented on a valid/ready output port.
- Sits between the activation/weight buffers and the post-processing/quantisation stage.

Parameters:
- NUM_LANES, 8: number of MAC lanes; power of 2, at least 2.
- ACC_WIDTH, 32: signed lane accumulator width.
- LEN_WIDTH, 16: width of the vector-length counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- precision_mode  in  2  00 = INT8, 01 = INT4 x2; 10/11 reserved, treated as INT8. Sampled on accepted start.
- cfg_len  in  LEN_WIDTH  beats per dot product. Sampled on accepted start.
- start  in  1  begin a dot product; accepted only in IDLE with cfg_len != 0.
- busy  out  1  high in any state other than IDLE.
- in_valid  in  1  act/wgt beat valid.
- in_ready  out  1  engine can accept a beat.
- act  in  NUM_LANES*8  lane i at bits [8i+7:8i].
- wgt  in  NUM_LANES*8  same packing as act.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_WIDTH+$clog2(NUM_LANES)  signed sum of all lanes.
- out_overflow  out  1  saturation flag (optional feature only).

Behaviour:
- Reset values: busy = 0, in_ready = 0, out_valid = 0, out_data = 0, out_overflow = 0, state = IDLE. Lane accumulators, counters and tree registers are all cleared.
- State machine:
  - IDLE -> ACCUM on start && cfg_len != 0. Latch cfg_len and precision_mode, clear lane accumulators and beat counter.
  - start with cfg_len == 0 is ignored.
  - ACCUM -> DRAIN on the accepted beat where beat counter == cfg_len-1.
  - DRAIN -> OUTPUT after $clog2(NUM_LANES) cycles.
  - OUTPUT -> IDLE on out_valid && out_ready.
- in_ready = 1 only in ACCUM.
- A beat is accepted when in_valid && in_ready. in_valid gaps are allowed: accumulators and counter hold.
- Lane product:
  - INT8: signed(a[7:0]) * signed(b[7:0]).
  - INT4: signed(a[7:4])*signed(b[7:4]) + signed(a[3:0])*signed(b[3:0]).
  - Sign-extended to ACC_WIDTH, added to the lane accumulator, two's-complement wrap.
- Reduction:
  - Binary tree, one register stage per level, $clog2(NUM_LANES) stages.
  - Width grows by 1 bit per level; no truncation.
- Latency: out_valid rises $clog2(NUM_LANES)+1 cycles after the last accepted beat.
- out_data and out_valid are stable while out_valid && !out_ready.
- start is ignored while busy; no queueing.
- A new start is accepted no earlier than the cycle after the output handshake.
- rst asserted mid-operation aborts immediately to reset values; no partial result is emitted.

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined:
  - Each lane accumulator saturates to the signed ACC_WIDTH bounds [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - A per-operation sticky flag sets if any lane saturated on any beat. It is cleared on accepted start.
  - The flag is presented on out_overflow, qualified by out_valid.
- Undefined: accumulators wrap; out_overflow is tied to 0.

Test Plan:
- INT8, defaults, cfg_len = 4, every lane act = 0x02, wgt = 0x03, continuous in_valid -> out_data = 192. out_valid exactly 4 cycles after the 4th accepted beat.
- INT4, cfg_len = 1, act = 0x2F (hi 2, lo -1), wgt = 0x33 -> 3 per lane, out_data = 24.
- INT8 negative, cfg_len = 1, act = 0x80, wgt = 0x7F -> -16256 per lane, out_data = -130048. Separately, in_valid toggling 1/0 over cfg_len = 3 -> result equals the continuous-input case.
- Backpressure: hold out_ready = 0 for 5 cycles in OUTPUT -> out_valid and out_data stable, in_ready = 0, start ignored. On out_ready = 1 the handshake completes and busy = 0 the next cycle.
- Reset: assert rst after 2 of 4 beats -> all outputs at reset values. A fresh start with cfg_len = 1, act = wgt = 0x01 -> out_data = 8 (no residue).
- ACC_WIDTH = 16, cfg_len = 2, act = wgt = 0x80 (16384 per beat):
  - With MAC_SATURATE_EN: each lane = 32767, out_data = 262136, out_overflow = 1.
  - Without: each lane wraps to -32768, out_data = -262144, out_overflow = 0.

Source files
------------

// File: rtl/mac_array_dotprod_engine.sv
// Dot-product engine: NUM_LANES INT8 / dual-INT4 MAC lanes accumulate cfg_len beats, then a
// registered adder tree reduces them. Define MAC_SATURATE_EN for saturating lanes and out_overflow.
module mac_array_dotprod_engine #(
  parameter int NUM_LANES = 8,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 16,
  localparam int LEVELS = $clog2(NUM_LANES),
  localparam int OUT_W  = ACC_WIDTH + LEVELS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             precision_mode,
  input  logic [LEN_WIDTH-1:0]   cfg_len,
  input  logic                   start,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_LANES*8-1:0] act,
  input  logic [NUM_LANES*8-1:0] wgt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_overflow,
  output logic [1:0]             dbg_state
);

  // Valid/ready: a transfer happens on a rising clk edge where valid && ready; the sender
  // holds valid and payload unchanged until that edge.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DRAIN  = 2'd2,
    S_OUTPUT = 2'd3
  } state_e;

  localparam logic [LEVELS-1:0] DRAIN_LAST = LEVELS'(LEVELS - 1);

  state_e                      state_q, state_d;
  logic [LEN_WIDTH-1:0]        len_q;
  logic [LEN_WIDTH-1:0]        beat_q;
  logic [LEVELS-1:0]           drain_q;
  logic                        int4_q;
  logic signed [ACC_WIDTH-1:0] acc_q [NUM_LANES];
  logic signed [ACC_WIDTH-1:0] acc_d [NUM_LANES];
  logic                        start_fire;
  logic                        beat_fire;
  logic                        last_beat;

  assign start_fire = (state_q == S_IDLE) && start && (cfg_len != '0);
  assign beat_fire  = in_valid && in_ready;
  assign last_beat  = (beat_q == len_q - LEN_WIDTH'(1));

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_OUTPUT);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_fire) state_d = S_ACCUM;
      S_ACCUM:  if (beat_fire && last_beat) state_d = S_DRAIN;
      S_DRAIN:  if (drain_q == DRAIN_LAST) state_d = S_OUTPUT;
      S_OUTPUT: if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

`ifdef MAC_SATURATE_EN
  logic [NUM_LANES-1:0] lane_sat;
  logic                 ovf_q;
`endif

  // Products are formed at 16 bits: INT8 max is 16384, the INT4 pair sum stays within [-112, 128].
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic signed [15:0]          a8, w8, ah, al, wh, wl, prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    assign a8 = 16'($signed(act[8*i +: 8]));
    assign w8 = 16'($signed(wgt[8*i +: 8]));
    assign ah = 16'($signed(act[8*i+4 +: 4]));
    assign al = 16'($signed(act[8*i +: 4]));
    assign wh = 16'($signed(wgt[8*i+4 +: 4]));
    assign wl = 16'($signed(wgt[8*i +: 4]));
    assign prod     = int4_q ? (ah * wh + al * wl) : (a8 * w8);
    assign prod_ext = ACC_WIDTH'(prod);
`ifdef MAC_SATURATE_EN
    logic [ACC_WIDTH:0] sum_ext;
    assign sum_ext     = {acc_q[i][ACC_WIDTH-1], acc_q[i]} + {prod_ext[ACC_WIDTH-1], prod_ext};
    assign lane_sat[i] = (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]);
    assign acc_d[i]    = !lane_sat[i] ? sum_ext[ACC_WIDTH-1:0] :
                         sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                              {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
    assign acc_d[i] = acc_q[i] + prod_ext;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      drain_q <= '0;
      int4_q  <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == S_DRAIN) ? drain_q + 1'b1 : '0;
      if (start_fire) begin
        len_q  <= cfg_len;
        int4_q <= (precision_mode == 2'b01);
        beat_q <= '0;
        for (int i = 0; i < NUM_LANES; i++) acc_q[i] <= '0;
      end else if (beat_fire) begin
        beat_q <= beat_q + LEN_WIDTH'(1);
        for (int i = 0; i < NUM_LANES; i++) acc_q[i] <= acc_d[i];
      end
    end
  end

`ifdef MAC_SATURATE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (start_fire) begin
      ovf_q <= 1'b0;
    end else if (beat_fire) begin
      ovf_q <= ovf_q | (|lane_sat);
    end
  end
  assign out_overflow = ovf_q & out_valid;
`else
  assign out_overflow = 1'b0;
`endif

  // Heap-ordered tree: node k sums kid[2k+1] and kid[2k+2]; indices NUM_LANES-1 and up are the
  // lane accumulators. Every leaf sits LEVELS registers below the root, so the root settles
  // exactly LEVELS cycles after the last accumulate. Nodes use the full output width.
  logic signed [OUT_W-1:0] node_q [NUM_LANES-1];
  logic signed [OUT_W-1:0] kid    [1:2*NUM_LANES-2];

  always_comb begin
    for (int k = 1; k < NUM_LANES - 1; k++) kid[k] = node_q[k];
    for (int j = 0; j < NUM_LANES; j++) kid[NUM_LANES-1+j] = OUT_W'(acc_q[j]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_LANES - 1; k++) node_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_LANES - 1; k++) node_q[k] <= kid[2*k+1] + kid[2*k+2];
    end
  end

  assign out_data = node_q[0];

endmodule

// File: tb/tb_mac_array_dotprod_engine.sv
// Bench for mac_array_dotprod_engine: default-width and ACC_WIDTH=16 instances share stimulus;
// results are checked against a lane-by-lane arithmetic model through expected queues.
module tb_mac_array_dotprod_engine;
  localparam int N    = 8;
  localparam int DW   = N * 8;
  localparam int LV   = $clog2(N);
  localparam int OW   = 32 + LV;
  localparam int OW16 = 16 + LV;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    precision_mode;
  logic [15:0]   cfg_len;
  logic          start, in_valid, out_ready;
  logic [DW-1:0] act, wgt;
  logic          busy, in_ready, out_valid, out_overflow;
  logic [OW-1:0] out_data;
  logic [1:0]    dbg_state;
  logic          busy16, in_ready16, out_valid16, out_overflow16;
  logic [OW16-1:0] out_data16;
  logic [1:0]    dbg_state16;

  mac_array_dotprod_engine u_dut (
    .clk(clk), .rst(rst), .precision_mode(precision_mode), .cfg_len(cfg_len),
    .start(start), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .act(act), .wgt(wgt), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_overflow(out_overflow), .dbg_state(dbg_state)
  );

  mac_array_dotprod_engine #(.ACC_WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .precision_mode(precision_mode), .cfg_len(cfg_len),
    .start(start), .busy(busy16), .in_valid(in_valid), .in_ready(in_ready16),
    .act(act), .wgt(wgt), .out_valid(out_valid16), .out_ready(out_ready),
    .out_data(out_data16), .out_overflow(out_overflow16), .dbg_state(dbg_state16)
  );

  int checks = 0;
  int errors = 0;
  logic [OW:0]   exp_q[$];
  logic [OW16:0] exp16_q[$];
  logic [DW-1:0] beat_a[$];
  logic [DW-1:0] beat_w[$];

  task automatic check(input string nm, input longint got, input longint expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint s4(input logic [3:0] x);
    logic signed [3:0] s;
    s = x;
    return longint'(s);
  endfunction

  function automatic longint s8(input logic [7:0] x);
    logic signed [7:0] s;
    s = x;
    return longint'(s);
  endfunction

  // Reference: per lane, sum the products of every accepted beat in plain integers, keeping the
  // running value inside a signed accw-bit range (clamped or wrapped), then add the lanes.
  function automatic void model(input int accw, input logic [1:0] mode,
                                output longint sum, output bit ovf);
    longint span, hi, lo, acc, p;
    logic [7:0] a, w;
    span = 64'sd1 <<< accw;
    hi = span / 2 - 1;
    lo = -(span / 2);
    sum = 0;
    ovf = 1'b0;
    for (int l = 0; l < N; l++) begin
      acc = 0;
      for (int b = 0; b < beat_a.size(); b++) begin
        a = beat_a[b][8*l +: 8];
        w = beat_w[b][8*l +: 8];
        if (mode == 2'b01) p = s4(a[7:4]) * s4(w[7:4]) + s4(a[3:0]) * s4(w[3:0]);
        else               p = s8(a) * s8(w);
        acc += p;
`ifdef MAC_SATURATE_EN
        if (acc > hi) begin acc = hi; ovf = 1'b1; end
        else if (acc < lo) begin acc = lo; ovf = 1'b1; end
`else
        if (acc > hi) acc -= span;
        else if (acc < lo) acc += span;
`endif
      end
      sum += acc;
    end
  endfunction

  // scoreboard: every cycle a result is presented it must match the head of the expected queue
  always @(negedge clk) begin : cmp
    logic [OW:0]   e;
    logic [OW16:0] e16;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) check("unexpected_result", 1, 0);
      else begin
        e = exp_q[0];
        check("out_data", $signed(out_data), $signed(e[OW-1:0]));
        check("out_overflow", out_overflow, e[OW]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (!rst && out_valid16) begin
      if (exp16_q.size() == 0) check("unexpected_result16", 1, 0);
      else begin
        e16 = exp16_q[0];
        check("out_data16", $signed(out_data16), $signed(e16[OW16-1:0]));
        check("out_overflow16", out_overflow16, e16[OW16]);
        if (out_ready) void'(exp16_q.pop_front());
      end
    end
  end

  // gap_mode: 0 continuous in_valid, 1 alternating 1/0, 2 random gaps.
  // hold: cycles of out_ready=0 (with start pulsed) before the handshake is allowed.
  task automatic run_op(input logic [1:0] mode, input int len, input bit fixed,
                        input logic [DW-1:0] fa, input logic [DW-1:0] fw,
                        input int gap_mode, input int bp_pct, input int hold,
                        output int lat, output longint msum, output longint msum16,
                        output bit movf16);
    int n, guard, k;
    bit v, done, ovf;
    logic [DW-1:0] a, w;
    beat_a.delete();
    beat_w.delete();
    precision_mode = mode;
    cfg_len = 16'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    n = 0; guard = 0; k = 0;
    while (n < len && guard < 200) begin
      a = fixed ? fa : {$urandom, $urandom};
      w = fixed ? fw : {$urandom, $urandom};
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (k % 2 == 0);
        default: v = ($urandom_range(99) >= 30);
      endcase
      in_valid = v; act = a; wgt = w;
      if (v && in_ready) begin
        beat_a.push_back(a);
        beat_w.push_back(w);
        n++;
      end
      tick();
      guard++; k++;
    end
    in_valid = 1'b0;
    if (n < len) check("beats_accepted", n, len);
    model(32, mode, msum, ovf);
    exp_q.push_back({ovf, OW'(msum)});
    model(16, mode, msum16, movf16);
    exp16_q.push_back({movf16, OW16'(msum16)});
    // latency counted from the cycle the last beat is presented
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
    if (hold > 0) begin
      out_ready = 1'b0;
      start = 1'b1;
      for (int h = 0; h < hold; h++) begin
        tick();
        check("hold_out_valid", out_valid, 1);
        check("hold_in_ready", in_ready, 0);
        check("hold_busy", busy, 1);
      end
      start = 1'b0;
    end
    done = 1'b0; guard = 0;
    while (!done && guard < 100) begin
      out_ready = ($urandom_range(99) >= bp_pct);
      done = out_valid && out_ready;
      tick();
      guard++;
    end
    out_ready = 1'b1;
    if (!done) check("handshake_timeout", 0, 1);
    check("busy_after_handshake", busy, 0);
    check("out_valid_after_handshake", out_valid, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int lat;
    longint s, s16, s_cont;
    bit o16;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; act = '0; wgt = '0;
    out_ready = 1'b1; precision_mode = 2'b00; cfg_len = '0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_overflow", out_overflow, 0);
    rst = 1'b0;
    tick();

    cfg_len = '0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_len_ignored", busy, 0);

    run_op(2'b00, 4, 1'b1, {N{8'h02}}, {N{8'h03}}, 0, 0, 0, lat, s, s16, o16);
    check("lat_int8", lat, LV + 1);
    check("model_int8", s, 192);

    run_op(2'b01, 1, 1'b1, {N{8'h2F}}, {N{8'h33}}, 0, 0, 0, lat, s, s16, o16);
    check("model_int4", s, 24);

    run_op(2'b00, 1, 1'b1, {N{8'h80}}, {N{8'h7F}}, 0, 0, 0, lat, s, s16, o16);
    check("model_int8_neg", s, -130048);

    run_op(2'b00, 3, 1'b1, {N{8'hF3}}, {N{8'h11}}, 0, 0, 0, lat, s_cont, s16, o16);
    check("model_cont", s_cont, -5304);
    run_op(2'b00, 3, 1'b1, {N{8'hF3}}, {N{8'h11}}, 1, 0, 0, lat, s, s16, o16);
    check("model_toggle", s, -5304);

    run_op(2'b00, 2, 1'b0, '0, '0, 2, 0, 5, lat, s, s16, o16);

    // abort mid-operation: two of four beats, then asynchronous reset
    precision_mode = 2'b00; cfg_len = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; act = {N{8'h07}}; wgt = {N{8'h09}};
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_out_overflow", out_overflow, 0);
    tick();
    rst = 1'b0;
    tick();
    run_op(2'b00, 1, 1'b1, {N{8'h01}}, {N{8'h01}}, 0, 0, 0, lat, s, s16, o16);
    check("model_after_abort", s, 8);

    run_op(2'b00, 2, 1'b1, {N{8'h80}}, {N{8'h80}}, 0, 0, 0, lat, s, s16, o16);
    check("model_wide_no_ovf", s, 262144);
`ifdef MAC_SATURATE_EN
    check("model_acc16_sat", s16, 262136);
    check("model_acc16_ovf", o16, 1);
`else
    check("model_acc16_wrap", s16, -262144);
    check("model_acc16_ovf", o16, 0);
`endif

    for (int r = 0; r < 25; r++) begin
      run_op(2'($urandom_range(3)), $urandom_range(1, 6), 1'b0, '0, '0, 2, 30, 0,
             lat, s, s16, o16);
    end

    repeat (3) tick();
    check("exp_q_drained", exp_q.size(), 0);
    check("exp16_q_drained", exp16_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
